// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset and qualifies pll_locked.
// Produces a stable lock_ok for reset generation, plus retry/loss counters.
module pll_lock_supervisor #(
    parameter int    U_DLY        = 1,
    parameter string SIMULATION   = "FALSE",
    parameter int    RST_HOLD_CYC = 16,
    parameter int    LOCK_TIMEOUT = 65536,
    parameter int    STABLE_CYC   = 1024,
    parameter int    MAX_RETRY    = 3
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_en,
    output logic       pll_rst_req,
    output logic       lock_ok,
    output logic       lock_fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    // U_DLY only shapes simulation timing elsewhere; it has no netlist effect.
    localparam int HOLD_CYC = RST_HOLD_CYC + (U_DLY * 0);
    localparam int TMO_CYC  = (SIMULATION == "TRUE") ? 256 : LOCK_TIMEOUT;
    localparam int STB_CYC  = (SIMULATION == "TRUE") ? 16 : STABLE_CYC;

    localparam logic [16:0] HOLD_LAST = 17'(HOLD_CYC - 1);
    localparam logic [16:0] TMO_LAST  = 17'(TMO_CYC - 1);
    localparam logic [16:0] STB_LAST  = 17'(STB_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [16:0] cnt;
    logic [16:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    logic [7:0]  lost_nxt;
    logic        sync1;
    logic        locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    // Next-state, counter and status-counter updates.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        lost_nxt  = lost_cnt;
        case (state)
            ST_RESET: begin
                if (cnt == HOLD_LAST)
                    state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TMO_LAST) begin
                    retry_nxt = retry_cnt + 4'd1;
                    if (retry_nxt == RETRY_MAX)
                        state_nxt = ST_FAIL;
                    else
                        state_nxt = ST_RESET;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == STB_LAST) begin
                    state_nxt = ST_LOCKED;
                    retry_nxt = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (!locked_s) begin
                    state_nxt = ST_RESET;
                    if (lost_cnt != 8'hFF)
                        lost_nxt = lost_cnt + 8'd1;
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
        // A soft restart overrides whatever the FSM decided this cycle.
        if (soft_rst_en) begin
            state_nxt = ST_RESET;
            retry_nxt = 4'd0;
            lost_nxt  = lost_cnt;
        end
        if (soft_rst_en || (state_nxt != state))
            cnt_nxt = 17'd0;
        else
            cnt_nxt = cnt + 17'd1;
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            cnt         <= 17'd0;
            pll_rst_req <= 1'b1;
            lock_ok     <= 1'b0;
            lock_fail   <= 1'b0;
            retry_cnt   <= 4'd0;
            lost_cnt    <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pll_rst_req <= (state_nxt == ST_RESET);
            lock_ok     <= (state_nxt == ST_LOCKED);
            lock_fail   <= (state_nxt == ST_FAIL);
            retry_cnt   <= retry_nxt;
            lost_cnt    <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with SIMULATION="TRUE" timing.
// Expected latencies come from the lock/timeout rules as cycle arithmetic.
module tb_pll_lock_supervisor;

    localparam int HOLD    = 16;
    localparam int TMO     = 256;
    localparam int STAB    = 16;
    localparam int RETRIES = 3;

    logic       clk_sys     = 1'b0;
    logic       clk_en      = 1'b1;
    logic       rst         = 1'b1;
    logic       pll_locked  = 1'b0;
    logic       soft_rst_en = 1'b0;
    logic       pll_rst_req;
    logic       lock_ok;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [7:0] lost_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int exp_lost    = 0;

    pll_lock_supervisor #(
        .U_DLY        (1),
        .SIMULATION   ("TRUE"),
        .RST_HOLD_CYC (HOLD),
        .LOCK_TIMEOUT (65536),
        .STABLE_CYC   (1024),
        .MAX_RETRY    (RETRIES)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .soft_rst_en (soft_rst_en),
        .pll_rst_req (pll_rst_req),
        .lock_ok     (lock_ok),
        .lock_fail   (lock_fail),
        .retry_cnt   (retry_cnt),
        .lost_cnt    (lost_cnt)
    );

    // Free-running reference clock that can be frozen.
    always #5 if (clk_en) clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       probe = pll_rst_req;
            1:       probe = lock_ok;
            default: probe = pll_rst_req | lock_fail;
        endcase
    endfunction

    // Edges taken until the probed output reaches val (bounded).
    task automatic run_until(input int sel, input logic val,
                             input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (probe(sel) !== val && n < limit);
    endtask

    // Drop lock for 1..3 cycles while locked, then expect recovery.
    task automatic lose_and_relock();
        int n;
        int len;
        len = $urandom_range(1, 3);
        pll_locked = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (n == len) pll_locked = 1'b1;
        end while (lock_ok === 1'b1 && n < 20);
        pll_locked = 1'b1;
        check("lost_fall", n, 3);
        if (exp_lost < 255) exp_lost++;
        check("lost_cnt", lost_cnt, exp_lost);
        check("lost_req", pll_rst_req, 1);
        run_until(0, 1'b0, 100, n);
        check("relock_hold", n, HOLD);
        run_until(1, 1'b1, 100, n);
        check("relock_lat", n, 1 + STAB);
    endtask

    initial begin
        int n;
        int d;
        int r;

        repeat (3) step();
        check("rst_req", pll_rst_req, 1);
        check("rst_lock_ok", lock_ok, 0);
        check("rst_fail", lock_fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        rst = 1'b0;

        // Normal lock.
        run_until(0, 1'b0, 100, n);
        check("hold_first", n, HOLD);
        repeat (10) step();
        pll_locked = 1'b1;
        run_until(1, 1'b1, 100, n);
        check("lock_lat", n, 2 + STAB + 1);
        check("lock_retry", retry_cnt, 0);
        check("lock_lost", lost_cnt, 0);
        check("lock_req", pll_rst_req, 0);

        for (int i = 0; i < 5; i++) lose_and_relock();

        // Soft restart on the same edge LOCKED would see loss of lock.
        pll_locked = 1'b0;
        step();
        step();
        soft_rst_en = 1'b1;
        step();
        soft_rst_en = 1'b0;
        check("soft_lock_ok", lock_ok, 0);
        check("soft_req", pll_rst_req, 1);
        check("soft_lost", lost_cnt, exp_lost);
        check("soft_retry", retry_cnt, 0);

        // No lock: three timeouts then FAIL.
        for (int k = 1; k <= RETRIES; k++) begin
            run_until(0, 1'b0, 100, n);
            check("nl_hold", n, HOLD);
            run_until(2, 1'b1, 1000, n);
            check("nl_wait", n, TMO);
            check("nl_retry", retry_cnt, k);
            check("nl_fail", lock_fail, k == RETRIES);
            check("nl_req", pll_rst_req, k != RETRIES);
        end
        n = 0;
        repeat (300) begin
            step();
            if (pll_rst_req !== 1'b0) n++;
        end
        check("fail_quiet", n, 0);
        check("fail_sticky", lock_fail, 1);
        check("fail_retry", retry_cnt, RETRIES);

        // Soft restart out of FAIL.
        soft_rst_en = 1'b1;
        step();
        soft_rst_en = 1'b0;
        check("sf_fail", lock_fail, 0);
        check("sf_retry", retry_cnt, 0);
        check("sf_req", pll_rst_req, 1);
        check("sf_lost", lost_cnt, exp_lost);
        run_until(0, 1'b0, 100, n);
        check("sf_hold", n, HOLD);
        run_until(2, 1'b1, 1000, n);
        check("sf_wait", n, TMO);
        check("sf_retry1", retry_cnt, 1);

        // Lock arrives mid-reset, then a one-cycle glitch in STABLE.
        r = $urandom_range(0, 12);
        repeat (r) step();
        pll_locked = 1'b1;
        run_until(0, 1'b0, 100, n);
        check("gl_hold", n, HOLD - r);
        d = $urandom_range(1, 14);
        repeat (d) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        check("gl_retry", retry_cnt, 1);
        check("gl_lock_ok", lock_ok, 0);
        // 2 sync edges to clear, 1 to re-enter STABLE, then a full window.
        run_until(1, 1'b1, 100, n);
        check("gl_lat", n, STAB + 3);
        check("gl_retry_clr", retry_cnt, 0);

        for (int i = 5; i < 300; i++) lose_and_relock();
        check("lost_sat", lost_cnt, 255);

        // Asynchronous reset with the clock frozen.
        check("pre_async", lock_ok, 1);
        clk_en = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        check("async_req", pll_rst_req, 1);
        check("async_lock_ok", lock_ok, 0);
        check("async_lost", lost_cnt, 0);
        check("async_fail", lock_fail, 0);
        check("async_retry", retry_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits between the system PLLs and sys_rst_gen, in the clk_sys (reference clock) domain.
- Drives the PLL reset.
- Supervises pll_locked: lock acquisition with a timeout, a lock-stability qualification window, loss-of-lock recovery and bounded retries.
- Produces a qualified lock_ok for reset generation, plus status counters for the config/status register space.

Parameters:
- U_DLY, 1: register assignment delay (simulation only).
- SIMULATION, "FALSE": "TRUE" replaces LOCK_TIMEOUT with 256 and STABLE_CYC with 16.
- RST_HOLD_CYC, 16: clk_sys cycles pll_rst_req is held high per reset attempt, range 2..255.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before an attempt is declared failed.
- STABLE_CYC, 1024: consecutive synchronized-locked cycles required before lock_ok asserts.
- MAX_RETRY, 3: failed attempts (timeouts) tolerated before entering FAIL, range 1..15.

Ports:
- clk_sys, input, 1: board reference clock; sole clock.
- rst, input, 1: asynchronous, active-high reset.
- pll_locked, input, 1: raw PLL lock (asynchronous to clk_sys); ANDed lock of all PLLs at top level.
- soft_rst_en, input, 1: single-cycle pulse from the config block; restarts the supervisor.
- pll_rst_req, output, 1: PLL reset (feeds rst_pll of the PLLs), active high.
- lock_ok, output, 1: qualified stable lock; feeds the pll_locked input of sys_rst_gen.
- lock_fail, output, 1: retry budget exhausted; sticky until soft_rst_en or rst.
- retry_cnt, output, 4: timeouts in the current acquisition sequence.
- lost_cnt, output, 8: loss-of-lock events since rst, saturating at 255.

Behaviour:
- pll_locked passes through a 2-flop synchronizer giving locked_s (2-cycle latency). All logic uses locked_s. All outputs are registered.
- One shared cycle counter cnt (17 bits) is cleared on every state change.
- rst high (asynchronous): state=RESET, cnt=0, pll_rst_req=1, lock_ok=0, lock_fail=0, retry_cnt=0, lost_cnt=0, synchronizer=0. Outputs take these values immediately, without a clock edge.
- RESET:
  - pll_rst_req=1, lock_ok=0.
  - When cnt==RST_HOLD_CYC-1, go to WAIT_LOCK.
  - pll_rst_req is therefore high for exactly RST_HOLD_CYC cycles per attempt (the first attempt counts from the first edge after rst release).
- WAIT_LOCK:
  - pll_rst_req=0.
  - locked_s=1: go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT-1: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RESET.
  - Same-cycle locked_s=1 and timeout: lock wins (go to STABLE, no increment).
- STABLE:
  - locked_s=0: return to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
  - When cnt==STABLE_CYC-1 with locked_s=1: go to LOCKED. lock_ok=1 is registered on that transition and retry_cnt is cleared.
- LOCKED:
  - lock_ok=1.
  - locked_s=0: lost_cnt+1 (saturating), lock_ok=0 on the same edge, go to RESET (pll_rst_req=1 on that edge).
- FAIL:
  - lock_fail=1, pll_rst_req=0, lock_ok=0. No automatic retry.
- soft_rst_en=1, in any state (highest priority, overrides same-cycle transitions):
  - Next state is RESET, cnt=0, lock_ok=0, lock_fail=0, retry_cnt=0.
  - lost_cnt is preserved.
- Minimum lock_ok latency from the first clk_sys edge that samples pll_locked=1 in WAIT_LOCK: 2 + STABLE_CYC + 1 cycles.
- Only states and outputs listed here are reachable. Illegal state encodings recover to RESET.

Test Plan (SIMULATION="TRUE", defaults otherwise):
- Normal lock:
  - Stimulus: release rst; raise pll_locked 10 cycles after pll_rst_req falls.
  - Required: pll_rst_req high exactly 16 cycles; lock_ok rises 19 cycles after pll_locked sampled high; retry_cnt=0, lost_cnt=0.
- No lock:
  - Stimulus: pll_locked held 0.
  - Required: three pll_rst_req pulses of 16 cycles, each followed by 256 low cycles; retry_cnt steps 1, 2, 3; lock_fail=1 on the third timeout; pll_rst_req stays 0 thereafter.
- Loss of lock:
  - Stimulus: after lock_ok=1, drop pll_locked for one cycle.
  - Required: lock_ok falls 3 cycles later; lost_cnt=1; pll_rst_req high 16 cycles; relock yields lock_ok again. Repeat 300 times: lost_cnt saturates at 255.
- Stability glitch:
  - Stimulus: drop pll_locked for 1 cycle at STABLE count 10.
  - Required: no lock_ok pulse; retry_cnt unchanged; lock_ok is asserted only after a fresh 16-cycle clean window.
- Soft restart from FAIL:
  - Stimulus: one-cycle soft_rst_en while in FAIL.
  - Required: lock_fail=0 and retry_cnt=0 next cycle; pll_rst_req high 16 cycles; lost_cnt retained. Also pulse soft_rst_en during LOCKED: lock_ok drops next cycle and lost_cnt is not incremented.
- Asynchronous reset:
  - Stimulus: assert rst mid-LOCKED with clk_sys stopped.
  - Required: pll_rst_req=1, lock_ok=0, lost_cnt=0 immediately, without a clock edge.
